// File: rtl/chip_ring_sequencer.sv
// ----------------------------------------------------------------------------
// chip_ring_sequencer
//
// Control-side sequencer for the ChIP ring reactors. On an accepted start it
// latches a ring mask, a per-phase dwell and a pump-stroke count. It then
// services every selected ring in ascending index order:
//   SETUP  (D cycles)    : inlet/outlet valves of the ring open, pump idle
//   PUMP   (3*N*D cycles): valves open, pump walks 110 -> 011 -> 101
//   CLOSE  (D cycles)    : valves closed, pump idle
//   FLUSH  (D cycles)    : flush valve open (only with CHIP_SEQ_FLUSH_EN)
// A one-cycle done pulse follows the last ring.
//
// Optional feature macro: CHIP_SEQ_FLUSH_EN
//   defined   -> FLUSH phase inserted after every CLOSE
//   undefined -> no FLUSH state; o_flush is tied 0
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   i_start             launch pulse, sampled only in IDLE
//   i_abort             synchronous abort, any state (outranks i_start)
//   i_ring_mask[SIZE]   rings to process, latched on accepted start
//   i_dwell[DWELL_W]    cycles per phase (0 behaves as 1)
//   i_strokes[CYC_W]    pump strokes per ring (0 behaves as 1)
//   o_busy              sequence in progress
//   o_done              one-cycle completion pulse
//   o_ctrl_ring_inlet   one-hot inlet valve drive
//   o_ctrl_ring_outlet  one-hot outlet valve drive
//   o_pump[3]           peristaltic valve pattern
//   o_flush             flush valve drive
//   o_cur_ring          index of the ring being serviced
// ----------------------------------------------------------------------------
module chip_ring_sequencer #(
    parameter int SIZE    = 8,
    parameter int DWELL_W = 16,
    parameter int CYC_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [SIZE-1:0]     i_ring_mask,
    input  logic [DWELL_W-1:0]  i_dwell,
    input  logic [CYC_W-1:0]    i_strokes,
    output logic                o_busy,
    output logic                o_done,
    output logic [SIZE-1:0]     o_ctrl_ring_inlet,
    output logic [SIZE-1:0]     o_ctrl_ring_outlet,
    output logic [2:0]          o_pump,
    output logic                o_flush,
    output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] o_cur_ring
);

    localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;

`ifdef CHIP_SEQ_FLUSH_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PUMP, S_CLOSE, S_FLUSH, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PUMP, S_CLOSE, S_DONE
    } state_t;
`endif

    // Lowest set mask bit at or above 'from'; MSB of the result flags "found".
    function automatic logic [RW:0] f_find(input logic [SIZE-1:0] mask, input int from);
        logic [RW:0] res;
        res = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                res = {1'b1, RW'(i)};
            end
        end
        return res;
    endfunction

    state_t             r_state, w_state;
    logic [RW-1:0]      r_ring, w_ring;
    logic [SIZE-1:0]    r_mask, w_mask;
    logic [DWELL_W-1:0] r_dwell_m1, w_dwell_m1;
    logic [CYC_W-1:0]   r_strokes_m1, w_strokes_m1;
    logic [DWELL_W-1:0] r_dcnt, w_dcnt;
    logic [CYC_W-1:0]   r_scnt, w_scnt;
    logic [1:0]         r_phase, w_phase;

    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic [SIZE-1:0]    r_valve, w_valve;
    logic [2:0]         r_pump, w_pump;
    logic               r_flush, w_flush;
    logic [RW-1:0]      r_cur, w_cur;

    logic [RW:0]        w_first;
    logic [RW:0]        w_next;
    logic [DWELL_W-1:0] w_in_dwell_m1;
    logic [CYC_W-1:0]   w_in_strokes_m1;

    // Zero-valued dwell/stroke settings are stored as "minus one" = 0, so the
    // counters can load the value directly and count down to zero.
    assign w_in_dwell_m1   = (i_dwell == '0)   ? '0 : i_dwell - DWELL_W'(1);
    assign w_in_strokes_m1 = (i_strokes == '0) ? '0 : i_strokes - CYC_W'(1);

    assign w_first = f_find(i_ring_mask, 0);
    assign w_next  = f_find(r_mask, int'(r_ring) + 1);

    always_comb begin
        w_state      = r_state;
        w_ring       = r_ring;
        w_mask       = r_mask;
        w_dwell_m1   = r_dwell_m1;
        w_strokes_m1 = r_strokes_m1;
        w_dcnt       = r_dcnt;
        w_scnt       = r_scnt;
        w_phase      = r_phase;

        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_mask       = i_ring_mask;
                    w_dwell_m1   = w_in_dwell_m1;
                    w_strokes_m1 = w_in_strokes_m1;
                    w_dcnt       = w_in_dwell_m1;
                    w_ring       = w_first[RW-1:0];
                    w_state      = w_first[RW] ? S_SETUP : S_DONE;
                end
            end
            S_SETUP: begin
                if (r_dcnt == '0) begin
                    w_dcnt  = r_dwell_m1;
                    w_scnt  = r_strokes_m1;
                    w_phase = 2'd0;
                    w_state = S_PUMP;
                end else begin
                    w_dcnt = r_dcnt - DWELL_W'(1);
                end
            end
            S_PUMP: begin
                // Phase advances every D cycles; a stroke ends after phase 2.
                if (r_dcnt == '0) begin
                    w_dcnt = r_dwell_m1;
                    if (r_phase == 2'd2) begin
                        w_phase = 2'd0;
                        if (r_scnt == '0) begin
                            w_state = S_CLOSE;
                        end else begin
                            w_scnt = r_scnt - CYC_W'(1);
                        end
                    end else begin
                        w_phase = r_phase + 2'd1;
                    end
                end else begin
                    w_dcnt = r_dcnt - DWELL_W'(1);
                end
            end
            S_CLOSE: begin
                if (r_dcnt == '0) begin
`ifdef CHIP_SEQ_FLUSH_EN
                    w_dcnt  = r_dwell_m1;
                    w_state = S_FLUSH;
`else
                    if (w_next[RW]) begin
                        w_ring  = w_next[RW-1:0];
                        w_dcnt  = r_dwell_m1;
                        w_state = S_SETUP;
                    end else begin
                        w_state = S_DONE;
                    end
`endif
                end else begin
                    w_dcnt = r_dcnt - DWELL_W'(1);
                end
            end
`ifdef CHIP_SEQ_FLUSH_EN
            S_FLUSH: begin
                if (r_dcnt == '0) begin
                    if (w_next[RW]) begin
                        w_ring  = w_next[RW-1:0];
                        w_dcnt  = r_dwell_m1;
                        w_state = S_SETUP;
                    end else begin
                        w_state = S_DONE;
                    end
                end else begin
                    w_dcnt = r_dcnt - DWELL_W'(1);
                end
            end
`endif
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (i_abort) begin
            w_state = S_IDLE;
        end
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe (SETUP visible the cycle after start).
    always_comb begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_valve = '0;
        w_pump  = 3'b000;
        w_flush = 1'b0;
        w_cur   = '0;

        case (w_state)
            S_SETUP: begin
                w_busy  = 1'b1;
                w_valve = SIZE'(1) << w_ring;
                w_cur   = w_ring;
            end
            S_PUMP: begin
                w_busy  = 1'b1;
                w_valve = SIZE'(1) << w_ring;
                w_cur   = w_ring;
                case (w_phase)
                    2'd0:    w_pump = 3'b110;
                    2'd1:    w_pump = 3'b011;
                    2'd2:    w_pump = 3'b101;
                    default: w_pump = 3'b000;
                endcase
            end
            S_CLOSE: begin
                w_busy = 1'b1;
                w_cur  = w_ring;
            end
`ifdef CHIP_SEQ_FLUSH_EN
            S_FLUSH: begin
                w_busy  = 1'b1;
                w_flush = 1'b1;
                w_cur   = w_ring;
            end
`endif
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ring       <= '0;
            r_mask       <= '0;
            r_dwell_m1   <= '0;
            r_strokes_m1 <= '0;
            r_dcnt       <= '0;
            r_scnt       <= '0;
            r_phase      <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_valve      <= '0;
            r_pump       <= 3'b000;
            r_flush      <= 1'b0;
            r_cur        <= '0;
        end else begin
            r_state      <= w_state;
            r_ring       <= w_ring;
            r_mask       <= w_mask;
            r_dwell_m1   <= w_dwell_m1;
            r_strokes_m1 <= w_strokes_m1;
            r_dcnt       <= w_dcnt;
            r_scnt       <= w_scnt;
            r_phase      <= w_phase;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_valve      <= w_valve;
            r_pump       <= w_pump;
            r_flush      <= w_flush;
            r_cur        <= w_cur;
        end
    end

    // Inlet and outlet share one register, so they can never disagree.
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_ctrl_ring_inlet  = r_valve;
    assign o_ctrl_ring_outlet = r_valve;
    assign o_pump             = r_pump;
    assign o_flush            = r_flush;
    assign o_cur_ring         = r_cur;

endmodule

// File: tb/tb_chip_ring_sequencer.sv
// ----------------------------------------------------------------------------
// tb_chip_ring_sequencer
//
// Scoreboard bench for chip_ring_sequencer. Each launched sequence is expanded
// into the per-cycle list of expected outputs (ring order, phase lengths and
// pump patterns taken straight from the sequencing rules) and queued. A monitor
// compares every cycle in which the DUT shows busy or done against the head of
// the queue, and checks that all outputs are 0 otherwise.
// ----------------------------------------------------------------------------
module tb_chip_ring_sequencer;

    localparam int SIZE = 8;
    localparam int DW   = 16;
    localparam int CW   = 8;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [7:0] valve;
        logic [2:0] pump;
        logic       flush;
        logic [2:0] ring;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [SIZE-1:0] ringMask;
    logic [DW-1:0]   dwell;
    logic [CW-1:0]   strokes;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] inlet;
    logic [SIZE-1:0] outlet;
    logic [2:0]      pump;
    logic            flush;
    logic [2:0]      curRing;

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    logic [2:0] pumpPat[3] = '{3'b110, 3'b011, 3'b101};

    chip_ring_sequencer #(.SIZE(SIZE), .DWELL_W(DW), .CYC_W(CW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_start            (start),
        .i_abort            (abort),
        .i_ring_mask        (ringMask),
        .i_dwell            (dwell),
        .i_strokes          (strokes),
        .o_busy             (busy),
        .o_done             (done),
        .o_ctrl_ring_inlet  (inlet),
        .o_ctrl_ring_outlet (outlet),
        .o_pump             (pump),
        .o_flush            (flush),
        .o_cur_ring         (curRing)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input int unsigned act, input int unsigned req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic d, input logic [7:0] v,
                                input logic [2:0] p, input logic f, input int r);
        exp_t e;
        e.busy  = b;
        e.done  = d;
        e.valve = v;
        e.pump  = p;
        e.flush = f;
        e.ring  = 3'(r);
        return e;
    endfunction

    // Reference model: expected cycle-by-cycle trace of one whole sequence.
    task automatic buildTrace(input logic [7:0] mask, input int d, input int n);
        int dd;
        int nn;
        logic [7:0] oh;
        dd = (d == 0) ? 1 : d;
        nn = (n == 0) ? 1 : n;
        for (int r = 0; r < SIZE; r++) begin
            if (mask[r]) begin
                oh = 8'(1) << r;
                for (int k = 0; k < dd; k++) expQ.push_back(mk(1, 0, oh, 3'b000, 0, r));
                for (int s = 0; s < nn; s++)
                    for (int p = 0; p < 3; p++)
                        for (int k = 0; k < dd; k++) expQ.push_back(mk(1, 0, oh, pumpPat[p], 0, r));
                for (int k = 0; k < dd; k++) expQ.push_back(mk(1, 0, 8'h00, 3'b000, 0, r));
`ifdef CHIP_SEQ_FLUSH_EN
                for (int k = 0; k < dd; k++) expQ.push_back(mk(1, 0, 8'h00, 3'b000, 1, r));
`endif
            end
        end
        expQ.push_back(mk(0, 1, 8'h00, 3'b000, 0, 0));
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checkOutput("inv_onehot0", 32'($onehot0(inlet)), 1);
            checkOutput("inv_in_eq_out", 32'(inlet == outlet), 1);
            if (pump != 3'b000) checkOutput("inv_pump_valves", 32'(busy && (inlet != '0)), 1);
            if (busy || done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", {busy, done}, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("busy", busy, e.busy);
                    checkOutput("done", done, e.done);
                    checkOutput("inlet", inlet, e.valve);
                    checkOutput("outlet", outlet, e.valve);
                    checkOutput("pump", pump, e.pump);
                    checkOutput("flush", flush, e.flush);
                    if (e.busy) checkOutput("cur_ring", curRing, e.ring);
                end
            end else begin
                checkOutput("idle_zero", {inlet, outlet, pump, flush, curRing}, 0);
            end
        end
    end

    // Waits for the queued trace to drain; ends at posedge+1 so a new start
    // lands in the cycle right after done.
    task automatic waitDone();
        int cyc;
        cyc = 0;
        while (expQ.size() != 0 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput("trace_left_over", expQ.size(), 0);
        expQ.delete();
        #1;
    endtask

    // Launches one sequence (called at posedge+1) and scrambles the config
    // inputs while busy; optionally pulses start again mid-run.
    task automatic applyStimulus(input logic [7:0] mask, input int d, input int n, input bit startAgain);
        start    = 1'b1;
        ringMask = mask;
        dwell    = DW'(d);
        strokes  = CW'(n);
        buildTrace(mask, d, n);
        @(posedge clk); #1;
        start    = 1'b0;
        ringMask = 8'($urandom);
        dwell    = DW'($urandom);
        strokes  = CW'($urandom);
        if (startAgain) begin
            @(posedge clk); #1;
            start    = 1'b1;
            ringMask = 8'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
        waitDone();
    endtask

    task automatic runAbort();
        int d, n, rlen, j;
        d    = $urandom_range(1, 3);
        n    = $urandom_range(1, 2);
        rlen = d * (3 * n + 2);
`ifdef CHIP_SEQ_FLUSH_EN
        rlen = rlen + d;
`endif
        j = 2 * rlen + d + $urandom_range(0, 3 * n * d - 1);
        start    = 1'b1;
        ringMask = 8'hFF;
        dwell    = DW'(d);
        strokes  = CW'(n);
        buildTrace(8'hFF, d, n);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (j) @(posedge clk);
        #1;
        checkOutput("abort_pre_pump", 32'(pump != 3'b000), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        expQ.delete();
        checkOutput("abort_all_zero", {busy, done, inlet, outlet, pump, flush, curRing}, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        ringMask = '0;
        dwell    = '0;
        strokes  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", {busy, done, inlet, outlet, pump, flush, curRing}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed sequences");
        applyStimulus(8'h05, 2, 1, 1'b0);
        applyStimulus(8'h00, 3, 2, 1'b0);
        applyStimulus(8'h80, 0, 0, 1'b0);
        applyStimulus(8'h21, 1, 2, 1'b1);
        applyStimulus(8'h40, 1, 255, 1'b0);

        $display("[TB] abort tests");
        runAbort();
        start    = 1'b1;
        abort    = 1'b1;
        ringMask = 8'h3C;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_with_abort", {busy, done}, 0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset mid-pump");
        start    = 1'b1;
        ringMask = 8'hFF;
        dwell    = 16'd2;
        strokes  = 8'd2;
        buildTrace(8'hFF, 2, 2);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("pre_reset_pump", pump, 3'b110);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_zero", {busy, done, inlet, outlet, pump, flush, curRing}, 0);
        expQ.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("busy_after_reset", busy, 0);

        $display("[TB] random sequences");
        for (int t = 0; t < 20; t++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus(m, $urandom_range(0, 4), $urandom_range(0, 3), (m != 8'h00) && t[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/chip_ring_sequencer.md
# chip_ring_sequencer

Parametrised control-side sequencer for the ChIP chip's SIZE ring reactors. It walks a latched ring mask in ascending index order. For each selected ring it opens that ring's inlet/outlet control valves, drives the three-valve peristaltic pump through a programmed number of strokes, then closes the ring. It sits between the host command register and the `pad_ctrl_*` / `pad_pump` control pads, replacing static per-pad drive with timed, registered valve actuation.

## Interface
- `SIZE`, 8, number of rings, ≥1; ring index width is `$clog2(SIZE)` (min 1).
- `DWELL_W`, 16, width of the per-phase dwell counter.
- `CYC_W`, 8, width of the pump-stroke count.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch pulse; sampled only in IDLE.
- `abort`  in  1  synchronous abort, any state.
- `ring_mask`  in  SIZE  rings to process; latched on accepted `start`.
- `dwell`  in  DWELL_W  cycles per phase; latched on `start`; 0 treated as 1.
- `strokes`  in  CYC_W  pump strokes per ring; latched on `start`; 0 treated as 1.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `ctrl_ring_inlet`  out  SIZE  one-hot inlet valve drive.
- `ctrl_ring_outlet`  out  SIZE  one-hot outlet valve drive.
- `pump`  out  3  peristaltic valve pattern.
- `flush`  out  1  flush valve drive (see Configuration).
- `cur_ring`  out  `$clog2(SIZE)`  index of ring being serviced.

## Operation
- **Registered outputs.** All outputs are registered. Reset and IDLE values are all 0.
- **States.** IDLE, SETUP, PUMP, CLOSE, FLUSH (present only with the macro), DONE.
- **IDLE.**
  - `start`=1 and `abort`=0: latch config. Go to SETUP at the lowest set bit of `ring_mask`.
  - Latched mask == 0: go straight to DONE.
- **SETUP** (D cycles): inlet and outlet bits of `cur_ring` = 1; `pump`=000.
- **PUMP** (3·N·D cycles):
  - Valves held open.
  - `pump` steps through phase0=110, phase1=011, phase2=101, each held D cycles.
  - One stroke = 3 phases.
- **CLOSE** (D cycles): valves 0, `pump`=000.
- **FLUSH** (D cycles, macro only): `flush`=1, valves 0.
- **After CLOSE/FLUSH.**
  - Next higher set mask bit: go to SETUP for that ring.
  - No further set bit: go to DONE.
- **DONE** (1 cycle): `done`=1, `busy`=0, then IDLE.
- **`busy`.** 1 in SETUP, PUMP, CLOSE and FLUSH.
- **Config changes mid-run.** `start` while busy is ignored. `ring_mask`, `dwell` and `strokes` changes while busy have no effect.
- **`abort`.**
  - On the next edge: go to IDLE with all outputs 0. No `done` pulse.
  - `abort` outranks `start` in the same cycle.
- **Reset mid-sequence.** All valves close immediately (asynchronous).
- **Valve invariant.** Inlet and outlet are never asserted for two rings in the same cycle.
- **Counters.**
  - Dwell counter is DWELL_W bits and counts D−1 down to 0.
  - Stroke counter is CYC_W bits.
  - With `dwell` at max and `strokes` at max there is no overflow.

## Timing
- **Start.** `start` accepted at edge t: first SETUP outputs are visible after edge t (cycle t+1); `busy` rises the same cycle.
- **Per ring.** D·(3N+2) cycles, plus D with FLUSH.
- **Completion.** `done` is asserted in the cycle following the last CLOSE/FLUSH cycle.
- **Ring transition.** Back-to-back, no idle cycle between rings.
- **Empty mask.** `done` at t+1, `busy` never set.
- **Repeated start.** `start` may be re-accepted in the cycle after `done`, i.e. once the block is back in IDLE.

## Configuration
- Macro `CHIP_SEQ_FLUSH_EN`.
- **Defined:** the FLUSH state is inserted after every CLOSE, asserting `flush` for D cycles.
- **Undefined:**
  - FLUSH state is not synthesised.
  - CLOSE goes directly to the next ring or DONE.
  - `flush` port remains and is tied 0.

## Test plan
- Reset with `rst_n`=0 mid-PUMP → all outputs 0 asynchronously; `busy`=0 after release.
- mask=8'h05, dwell=2, strokes=1, no flush → ring0 then ring2, 10 cycles each; `busy` for 20 cycles; `done` 21 cycles after start; pump sequence 110,110,011,011,101,101 per ring.
- Same stimulus with `CHIP_SEQ_FLUSH_EN` → 24 busy cycles; `flush` high 2 cycles after each ring's CLOSE.
- mask=0 → `done` 1 cycle after start, `busy` stays 0; dwell=0, strokes=0, mask=8'h80 → behaves as D=1, N=1: 5 cycles on ring 7.
- `abort` in PUMP of ring 2 (mask=8'hFF) → all outputs 0 next cycle, no `done`; `start` while busy ignored; start+abort in same cycle → stays IDLE.
- Assertion across random runs: `$onehot0` on inlet and outlet; `pump`≠000 only in PUMP; inlet==outlet every cycle.
